// File: rtl/sccb_init_sequencer.sv
// SCCB register-init sequencer: walks a ROM table, issues writes,
// inserts ms delays and retries NACKed writes.
module sccb_init_sequencer #(
    parameter int AW        = 8,
    parameter int MS_CYCLES = 24000,
    parameter int MAX_RETRY = 3
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    output logic          done,
    output logic          error,
    output logic [AW-1:0] rom_addr,
    input  logic [15:0]   rom_data,
    output logic          wr_req,
    output logic [7:0]    wr_reg,
    output logic [7:0]    wr_data,
    input  logic          wr_ack,
    input  logic          wr_nack,
    output logic [AW-1:0] entry_cnt
);

    localparam int PW = (MS_CYCLES > 1) ? $clog2(MS_CYCLES) : 1;
    localparam int RW = $clog2(MAX_RETRY + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_WRITE, S_GAP, S_DELAY, S_DONE
    } state_t;

    state_t          r_state, w_state;
    logic            r_done, w_done;
    logic            r_error, w_error;
    logic            r_wr_req, w_wr_req;
    logic [7:0]      r_wr_reg, w_wr_reg;
    logic [7:0]      r_wr_data, w_wr_data;
    logic [AW-1:0]   r_rom_addr, w_rom_addr;
    logic [AW-1:0]   r_entry_cnt, w_entry_cnt;
    logic [RW-1:0]   r_retry, w_retry;
    logic [PW-1:0]   r_pre, w_pre;
    logic [7:0]      r_ms, w_ms;

    logic w_go_idle, w_adv, w_fin, w_fin_err;
    logic w_end, w_dly, w_last;
    logic [RW-1:0] w_retry_inc;

    assign w_end       = (rom_data == 16'hFFFF);
    assign w_dly       = (rom_data[15:8] == 8'hFE);
    assign w_last      = (r_rom_addr == {AW{1'b1}});
    assign w_retry_inc = r_retry + 1'b1;

    always_comb begin
        w_state     = r_state;
        w_done      = r_done;
        w_error     = r_error;
        w_wr_req    = r_wr_req;
        w_wr_reg    = r_wr_reg;
        w_wr_data   = r_wr_data;
        w_rom_addr  = r_rom_addr;
        w_entry_cnt = r_entry_cnt;
        w_retry     = r_retry;
        w_pre       = r_pre;
        w_ms        = r_ms;
        w_go_idle   = 1'b0;
        w_adv       = 1'b0;
        w_fin       = 1'b0;
        w_fin_err   = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state     = S_FETCH;
                    w_rom_addr  = '0;
                    w_entry_cnt = '0;
                    w_retry     = '0;
                end
            end
            S_FETCH: begin
                if (!start) w_go_idle = 1'b1;
                else        w_state   = S_DECODE;
            end
            S_DECODE: begin
                if (!start) begin
                    w_go_idle = 1'b1;
                end else begin
                    unique case (1'b1)
                        w_end: w_fin = 1'b1;
                        w_dly: begin
                            if (rom_data[7:0] == 8'd0) begin
                                w_adv = 1'b1;
                            end else begin
                                w_state = S_DELAY;
                                w_ms    = rom_data[7:0];
                                w_pre   = '0;
                            end
                        end
                        default: begin
                            w_wr_reg  = rom_data[15:8];
                            w_wr_data = rom_data[7:0];
                            w_wr_req  = 1'b1;
                            w_state   = S_WRITE;
                        end
                    endcase
                end
            end
            S_WRITE: begin
                // Simultaneous ack and nack counts as a failed write.
                if (wr_nack) begin
                    w_wr_req = 1'b0;
                    w_retry  = w_retry_inc;
                    if (!start) begin
                        w_go_idle = 1'b1;
                    end else if (int'(w_retry_inc) < MAX_RETRY) begin
                        w_state = S_GAP;
                    end else begin
                        w_fin     = 1'b1;
                        w_fin_err = 1'b1;
                    end
                end else if (wr_ack) begin
                    w_wr_req    = 1'b0;
                    w_entry_cnt = r_entry_cnt + 1'b1;
                    w_retry     = '0;
                    if (!start) w_go_idle = 1'b1;
                    else        w_adv     = 1'b1;
                end
            end
            S_GAP: begin
                if (!start) begin
                    w_go_idle = 1'b1;
                end else begin
                    w_wr_req = 1'b1;
                    w_state  = S_WRITE;
                end
            end
            S_DELAY: begin
                if (!start) begin
                    w_go_idle = 1'b1;
                end else if (r_pre == PW'(MS_CYCLES - 1)) begin
                    w_pre = '0;
                    if (r_ms == 8'd1) w_adv = 1'b1;
                    else              w_ms  = r_ms - 8'd1;
                end else begin
                    w_pre = r_pre + 1'b1;
                end
            end
            S_DONE: begin
                if (!start) w_go_idle = 1'b1;
            end
            default: w_go_idle = 1'b1;
        endcase

        // A table without an end marker stops at the last address.
        if (w_adv) begin
            if (w_last) begin
                w_fin = 1'b1;
            end else begin
                w_rom_addr = r_rom_addr + 1'b1;
                w_state    = S_FETCH;
            end
        end

        if (w_fin) begin
            w_state = S_DONE;
            w_done  = 1'b1;
            w_error = w_fin_err;
        end

        if (w_go_idle) begin
            w_state     = S_IDLE;
            w_done      = 1'b0;
            w_error     = 1'b0;
            w_wr_req    = 1'b0;
            w_wr_reg    = '0;
            w_wr_data   = '0;
            w_rom_addr  = '0;
            w_entry_cnt = '0;
            w_retry     = '0;
            w_pre       = '0;
            w_ms        = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_wr_req    <= 1'b0;
            r_wr_reg    <= '0;
            r_wr_data   <= '0;
            r_rom_addr  <= '0;
            r_entry_cnt <= '0;
            r_retry     <= '0;
            r_pre       <= '0;
            r_ms        <= '0;
        end else begin
            r_state     <= w_state;
            r_done      <= w_done;
            r_error     <= w_error;
            r_wr_req    <= w_wr_req;
            r_wr_reg    <= w_wr_reg;
            r_wr_data   <= w_wr_data;
            r_rom_addr  <= w_rom_addr;
            r_entry_cnt <= w_entry_cnt;
            r_retry     <= w_retry;
            r_pre       <= w_pre;
            r_ms        <= w_ms;
        end
    end

    assign done      = r_done;
    assign error     = r_error;
    assign wr_req    = r_wr_req;
    assign wr_reg    = r_wr_reg;
    assign wr_data   = r_wr_data;
    assign rom_addr  = r_rom_addr;
    assign entry_cnt = r_entry_cnt;

endmodule
